trng_axil_fifo_reg: RTL

- AXI4-Lite read-only slave that buffers TRNG output for the PS.
- Packs a stream of validated TRNG bytes into 32-bit words and queues them in a parameterised FIFO.
- Exposes DATA, STATUS and CONFIG registers with a full AR/R handshake (ARREADY, RREADY, RRESP).
- Sits between the PL entropy source and the PS interconnect, replacing the single-byte, unbuffered read register.

---
 rtl/trng_axil_fifo_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/trng_axil_fifo_reg.sv
// AXI4-Lite read-only slave that packs TRNG bytes into 32-bit words and buffers them in a FIFO.
// Registers: DATA (pop), STATUS (sticky flags clear on read), CONFIG (constant).
module trng_axil_fifo_reg #(
   parameter int BYTES_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 16,
   parameter int ADDR_W         = 4
) (
   input  logic              S_AXI_ACLK,
   input  logic              S_AXI_ARESET,
   input  logic [ADDR_W-1:0] S_AXI_ARADDR,
   input  logic              S_AXI_ARVALID,
   output logic              S_AXI_ARREADY,
   output logic [31:0]       S_AXI_RDATA,
   output logic [1:0]        S_AXI_RRESP,
   output logic              S_AXI_RVALID,
   input  logic              S_AXI_RREADY,
   input  logic [7:0]        trng_byte,
   input  logic              trng_valid,
   output logic              fifo_nonempty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [0:0]       state;
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   level;
   logic [PTR_W:0]   level_next;
   logic [2:0]       byte_cnt;
   logic [31:0]      word_acc;
   logic [31:0]      push_word;
   logic             overflow;
   logic             underflow;

   logic             empty;
   logic             full;
   logic             last_byte;
   logic             ar_accept;
   logic [1:0]       word_idx;
   logic             pop;
   logic             push_ok;
   logic             ovf_set;
   logic             unf_set;
   logic             sts_clr;
   logic [31:0]      rd_data;
   logic [1:0]       rd_resp;
   logic             unused_addr;

   assign unused_addr = ^S_AXI_ARADDR;

   assign empty     = (level == '0);
   assign full      = (level == (PTR_W+1)'(FIFO_DEPTH));
   assign last_byte = trng_valid && !S_AXI_ARESET &&
                      (byte_cnt == 3'(BYTES_PER_WORD - 1));
   // The completing byte is merged combinationally so it lands in the pushed word.
   assign push_word = word_acc | ({24'b0, trng_byte} << {byte_cnt, 3'b000});

   assign word_idx  = S_AXI_ARADDR[3:2];
   assign ar_accept = (state == ST_IDLE) && S_AXI_ARVALID && !S_AXI_ARESET;
   assign pop       = ar_accept && (word_idx == 2'd0) && !empty;
   assign push_ok   = last_byte && (!full || pop);
   assign ovf_set   = last_byte && full && !pop;
   assign unf_set   = ar_accept && (word_idx == 2'd0) && empty;
   assign sts_clr   = ar_accept && (word_idx == 2'd1);

   assign level_next = level + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

   assign S_AXI_ARREADY = (state == ST_IDLE);

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (word_idx)
         2'd0: rd_data = empty ? '0 : mem[rd_ptr];
         2'd1: begin
            rd_data[0]    = empty;
            rd_data[1]    = full;
            rd_data[2]    = overflow;
            rd_data[3]    = underflow;
            rd_data[6:4]  = byte_cnt;
            rd_data[15:8] = 8'(level);
         end
         2'd2: begin
            rd_data[7:0]  = 8'(BYTES_PER_WORD);
            rd_data[23:8] = 16'(FIFO_DEPTH);
         end
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state         <= ST_IDLE;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
         fifo_nonempty <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         byte_cnt      <= '0;
         word_acc      <= '0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         if (trng_valid) begin
            if (last_byte) begin
               byte_cnt <= '0;
               word_acc <= '0;
            end else begin
               byte_cnt <= byte_cnt + 3'd1;
               word_acc <= push_word;
            end
         end

         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         level         <= level_next;
         fifo_nonempty <= (level_next != '0);

         // Set events take priority over the STATUS read clear.
         if (ovf_set)      overflow <= 1'b1;
         else if (sts_clr) overflow <= 1'b0;
         if (unf_set)      underflow <= 1'b1;
         else if (sts_clr) underflow <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (ar_accept) begin
                  S_AXI_RDATA  <= rd_data;
                  S_AXI_RRESP  <= rd_resp;
                  S_AXI_RVALID <= 1'b1;
                  state        <= ST_RESP;
               end
            end
            default: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
